// File: rtl/a5_stream_ctrl.sv
// A5/1 session sequencer: serial key load, warm-up, 8 core steps per byte, XOR with input stream.
// Per byte: 9 GEN + 1 WAIT_IN + 1 OUT cycles minimum; the core is frozen while in/out handshakes stall.
module a5_stream_ctrl #(
  parameter int WARMUP = 100
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        abort,
  input  logic [63:0] key,
  input  logic [15:0] byte_count,
  input  logic [7:0]  in_byte,
  input  logic        in_valid,
  output logic        in_ready,
  output logic [7:0]  out_byte,
  output logic        out_valid,
  input  logic        out_ready,
  output logic        core_load,
  output logic        core_key_bit,
  output logic        core_step,
  input  logic        core_ks_bit,
  output logic        busy,
  output logic        done
);

  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_LOAD    = 3'd1;
  localparam logic [2:0] S_WARM    = 3'd2;
  localparam logic [2:0] S_GEN     = 3'd3;
  localparam logic [2:0] S_WAIT_IN = 3'd4;
  localparam logic [2:0] S_OUT     = 3'd5;
  localparam logic [2:0] S_DONE    = 3'd6;

  localparam logic [15:0] WARM_LAST = (WARMUP > 0) ? 16'(WARMUP - 1) : 16'd0;
  localparam bit          HAS_WARM  = (WARMUP > 0);

  logic [2:0]  state;
  logic [63:0] key_q;
  logic [15:0] remaining;
  logic [15:0] cnt;
  logic [7:0]  ks_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= S_IDLE;
      key_q     <= '0;
      remaining <= '0;
      cnt       <= '0;
      ks_q      <= '0;
      out_byte  <= '0;
    end else if (abort && (state != S_IDLE)) begin
      state <= S_IDLE;
      cnt   <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (start) begin
            key_q     <= key;
            remaining <= byte_count;
            cnt       <= '0;
            state     <= S_LOAD;
          end
        end
        S_LOAD: begin
          if (cnt == 16'd63) begin
            cnt <= '0;
            if (HAS_WARM)
              state <= S_WARM;
            else
              state <= (remaining != 16'd0) ? S_GEN : S_DONE;
          end else begin
            cnt <= cnt + 16'd1;
          end
        end
        S_WARM: begin
          if (cnt == WARM_LAST) begin
            cnt   <= '0;
            state <= (remaining != 16'd0) ? S_GEN : S_DONE;
          end else begin
            cnt <= cnt + 16'd1;
          end
        end
        S_GEN: begin
          // core_ks_bit lags core_step by one edge, so capture runs at g=1..8
          if (cnt != 16'd0)
            ks_q <= {core_ks_bit, ks_q[7:1]};
          if (cnt == 16'd8) begin
            cnt   <= '0;
            state <= S_WAIT_IN;
          end else begin
            cnt <= cnt + 16'd1;
          end
        end
        S_WAIT_IN: begin
          if (in_valid) begin
            out_byte <= in_byte ^ ks_q;
            state    <= S_OUT;
          end
        end
        S_OUT: begin
          if (out_ready) begin
            remaining <= (remaining != 16'd0) ? remaining - 16'd1 : 16'd0;
            state     <= (remaining <= 16'd1) ? S_DONE : S_GEN;
          end
        end
        S_DONE:  state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

  assign core_load    = (state == S_LOAD);
  assign core_key_bit = core_load & key_q[cnt[5:0]];
  assign core_step    = (state == S_WARM) || ((state == S_GEN) && (cnt < 16'd8));
  assign in_ready     = (state == S_WAIT_IN);
  assign out_valid    = (state == S_OUT);
  assign busy         = (state != S_IDLE);
  assign done         = (state == S_DONE);

endmodule

// File: tb/tb_a5_stream_ctrl.sv
// Randomized bench for a5_stream_ctrl: behavioural keystream core model plus byte scoreboard.
module tb_a5_stream_ctrl;
  localparam int WARMUP = 100;
  localparam int NBITS  = 8192;

  logic        clk = 1'b0;
  logic        rst, start, abort;
  logic [63:0] key;
  logic [15:0] byte_count;
  logic [7:0]  in_byte;
  logic        in_valid, in_ready;
  logic [7:0]  out_byte;
  logic        out_valid, out_ready;
  logic        core_load, core_key_bit, core_step;
  logic        core_ks_bit = 1'b0;
  logic        busy, done;

  always #5 clk = ~clk;

  a5_stream_ctrl #(.WARMUP(WARMUP)) dut (
    .clk(clk), .rst(rst), .start(start), .abort(abort), .key(key),
    .byte_count(byte_count), .in_byte(in_byte), .in_valid(in_valid),
    .in_ready(in_ready), .out_byte(out_byte), .out_valid(out_valid),
    .out_ready(out_ready), .core_load(core_load), .core_key_bit(core_key_bit),
    .core_step(core_step), .core_ks_bit(core_ks_bit), .busy(busy), .done(done)
  );

  int vectors = 0;
  int miscompares = 0;

  // Keystream core model: step n presents ks_bits[n] on the following cycle
  bit ks_bits [NBITS];
  int step_n = 0;
  always @(posedge clk) begin
    if (core_step) begin
      core_ks_bit <= ks_bits[step_n % NBITS];
      step_n      <= step_n + 1;
    end
  end

  logic [7:0] exp_q [$];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic timeout_fail(input string name);
    vectors++;
    miscompares++;
    $display("FAIL %s: timed out waiting for DUT", name);
  endtask

  // Monitor statistics, sampled on the falling edge
  int ncyc = 0, load_first = 0, load_n = 0, gen_first = 0, done_ncyc = 0;
  int steps_since = 0, step_total = 0, load_total = 0, done_total = 0;
  int in_rdy_total = 0, ov_total = 0, overlap = 0, stall_steps = 0, unstable = 0;
  logic [63:0] keycap = '0;
  bit load_prev = 0, prev_ov = 0, prev_hs = 0;
  logic [7:0] prev_ob = '0;

  always @(negedge clk) begin
    ncyc++;
    if (core_load === 1'b1) begin
      if (!load_prev) begin
        load_first  = ncyc;
        load_n      = 0;
        steps_since = 0;
      end
      keycap[load_n % 64] = core_key_bit;
      load_n++;
      load_total++;
    end
    if (core_step === 1'b1) begin
      if (steps_since == WARMUP) gen_first = ncyc;
      steps_since++;
      step_total++;
      if (core_load === 1'b1) overlap++;
      if (in_ready === 1'b1 || out_valid === 1'b1) stall_steps++;
    end
    if (done === 1'b1) begin
      done_total++;
      done_ncyc = ncyc;
    end
    if (in_ready === 1'b1) in_rdy_total++;
    if (out_valid === 1'b1) ov_total++;
    if (out_valid === 1'b1 && prev_ov && !prev_hs && out_byte !== prev_ob) unstable++;
    if (out_valid === 1'b1 && out_ready === 1'b1) begin
      if (exp_q.size() == 0) begin
        vectors++;
        miscompares++;
        $display("FAIL scoreboard: got %0h with no expected byte queued", out_byte);
      end else begin
        check("scoreboard", {56'd0, out_byte}, {56'd0, exp_q.pop_front()});
      end
    end
    load_prev = (core_load === 1'b1);
    prev_ov   = (out_valid === 1'b1);
    prev_hs   = (out_valid === 1'b1) && (out_ready === 1'b1);
    prev_ob   = out_byte;
  end

  function automatic logic [7:0] ks_model(input int base, input int k);
    logic [7:0] b;
    for (int i = 0; i < 8; i++) b[i] = ks_bits[(base + WARMUP + 8 * k + i) % NBITS];
    return b;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic start_session(input logic [63:0] k, input logic [15:0] n, output int base);
    base       = step_n;
    key        = k;
    byte_count = n;
    start      = 1'b1;
    tick();
    start      = 1'b0;
  endtask

  task automatic do_byte(input int base, input int k, input logic [7:0] pt,
                         input int in_dly, input int out_dly, output logic [7:0] ob);
    bit ok = 0;
    ob = '0;
    for (int i = 0; i < 2000; i++) begin
      if (in_ready) begin ok = 1; break; end
      tick();
    end
    if (!ok) begin timeout_fail("in_ready_wait"); return; end
    repeat (in_dly) begin
      tick();
      check("in_ready_stall", in_ready, 1);
      check("step_in_stall", core_step, 0);
    end
    in_byte  = pt;
    in_valid = 1'b1;
    exp_q.push_back(pt ^ ks_model(base, k));
    tick();
    in_valid = 1'b0;
    ob = out_byte;
    check("out_valid_set", out_valid, 1);
    repeat (out_dly) begin
      tick();
      check("out_hold_valid", out_valid, 1);
      check("out_hold_byte", out_byte, ob);
      check("step_out_stall", core_step, 0);
    end
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
  endtask

  task automatic finish_session();
    check("done_pulse", done, 1);
    tick();
    check("done_one_cycle", done, 0);
    check("idle_busy", busy, 0);
  endtask

  task automatic run_random(input int n);
    int base;
    logic [7:0] ob;
    start_session({$urandom, $urandom}, 16'(n), base);
    for (int k = 0; k < n; k++)
      do_byte(base, k, 8'($urandom), $urandom_range(0, 3), $urandom_range(0, 3), ob);
    finish_session();
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int base, s0, d0, r0, v0;
    logic [7:0] ob;
    bit ok;
    logic [7:0] pat;
    for (int i = 0; i < NBITS; i++) ks_bits[i] = bit'($urandom_range(0, 1));
    rst = 1'b1; start = 0; abort = 0; key = '0; byte_count = '0;
    in_byte = '0; in_valid = 0; out_ready = 0;
    tick();
    tick();
    check("rst_in_ready", in_ready, 0);
    check("rst_out_valid", out_valid, 0);
    check("rst_out_byte", out_byte, 0);
    check("rst_core_load", core_load, 0);
    check("rst_core_step", core_step, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    rst = 1'b0;
    tick();

    // Key load + known-keystream encrypt
    pat = 8'h4D;
    base = step_n;
    for (int i = 0; i < 8; i++) ks_bits[(base + WARMUP + i) % NBITS] = pat[i];
    s0 = step_total;
    start_session(64'h0123456789ABCDEF, 16'd1, base);
    do_byte(base, 0, 8'hFF, 0, 0, ob);
    check("encrypt_byte", ob, 8'hB2);
    finish_session();
    check("load_cycles", load_n, 64);
    check("key_bits", keycap, 64'h0123456789ABCDEF);
    check("first_gen_time", gen_first - load_first, 64 + WARMUP);
    check("steps_1byte", step_total - s0, WARMUP + 8);

    // Backpressure on both sides
    s0 = step_total;
    start_session({$urandom, $urandom}, 16'd2, base);
    for (int k = 0; k < 2; k++) do_byte(base, k, 8'($urandom), 4, 5, ob);
    finish_session();
    check("steps_2byte", step_total - s0, WARMUP + 16);

    // Zero length
    r0 = in_rdy_total; v0 = ov_total;
    start_session({$urandom, $urandom}, 16'd0, base);
    ok = 0;
    for (int i = 0; i < 400; i++) begin
      if (done) begin ok = 1; break; end
      tick();
    end
    if (!ok) timeout_fail("zero_len_done");
    tick();
    check("zero_len_done_time", done_ncyc - load_first, 64 + WARMUP);
    check("zero_len_busy", busy, 0);
    check("zero_len_in_ready", in_rdy_total - r0, 0);
    check("zero_len_out_valid", ov_total - v0, 0);

    // Abort while waiting for input
    d0 = done_total;
    start_session({$urandom, $urandom}, 16'd3, base);
    ok = 0;
    for (int i = 0; i < 400; i++) begin
      if (in_ready) begin ok = 1; break; end
      tick();
    end
    if (!ok) timeout_fail("abort_wait");
    abort = 1'b1;
    tick();
    abort = 1'b0;
    check("abort_busy", busy, 0);
    check("abort_in_ready", in_ready, 0);
    check("abort_out_valid", out_valid, 0);
    tick();
    tick();
    check("abort_no_done", done_total - d0, 0);

    // start pulsed during WARM is ignored
    s0 = step_total;
    start_session({$urandom, $urandom}, 16'd1, base);
    ok = 0;
    for (int i = 0; i < 400; i++) begin
      if (core_step && !core_load) begin ok = 1; break; end
      tick();
    end
    if (!ok) timeout_fail("warm_wait");
    repeat (10) tick();
    key = {$urandom, $urandom}; byte_count = 16'd5; start = 1'b1;
    tick();
    start = 1'b0;
    do_byte(base, 0, 8'($urandom), 1, 1, ob);
    finish_session();
    check("warm_start_gen_time", gen_first - load_first, 64 + WARMUP);
    check("warm_start_steps", step_total - s0, WARMUP + 8);

    // Reset mid-GEN, then a normal session
    start_session({$urandom, $urandom}, 16'd2, base);
    ok = 0;
    for (int i = 0; i < 400; i++) begin
      if (steps_since > WARMUP + 2) begin ok = 1; break; end
      tick();
    end
    if (!ok) timeout_fail("gen_wait");
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    check("midrst_in_ready", in_ready, 0);
    check("midrst_out_valid", out_valid, 0);
    check("midrst_out_byte", out_byte, 0);
    check("midrst_core_load", core_load, 0);
    check("midrst_core_key_bit", core_key_bit, 0);
    check("midrst_core_step", core_step, 0);
    check("midrst_busy", busy, 0);
    check("midrst_done", done, 0);
    tick();
    run_random(2);

    for (int s = 0; s < 5; s++) run_random($urandom_range(1, 3));

    tick();
    tick();
    check("stall_steps", stall_steps, 0);
    check("load_step_overlap", overlap, 0);
    check("out_unstable", unstable, 0);
    check("scoreboard_empty", exp_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/a5_stream_ctrl.md
# a5_stream_ctrl

Session sequencer for the A5/1 keystream core. It loads a 64-bit key into the core serially and runs the warm-up steps. It then clocks the core 8 steps per byte, assembles each keystream byte LSB-first, and XORs it with bytes taken over a valid/ready input stream. Ciphertext bytes are presented on a valid/ready output stream. It sits between the byte source/sink (image buffer) and the cipher core, and is the only block driving the core's load/step controls.

## Interface
Parameters:
- WARMUP, 100: number of discarded keystream steps after key load; 0 skips the warm-up phase.

Ports (single clock `clk`; synchronous active-high reset `rst`):
- clk  in  1  system clock; all logic on rising edge
- rst  in  1  synchronous, active-high reset
- start  in  1  begin a session; sampled only in IDLE
- abort  in  1  synchronous cancel; returns to IDLE from any state
- key  in  64  session key; latched on accepted start
- byte_count  in  16  bytes to process; latched on accepted start
- in_byte  in  8  plaintext byte
- in_valid  in  1  in_byte valid
- in_ready  out  1  controller accepts in_byte this cycle
- out_byte  out  8  ciphertext byte (registered)
- out_valid  out  1  out_byte valid
- out_ready  in  1  sink accepts out_byte
- core_load  out  1  core in key-shift mode
- core_key_bit  out  1  serial key bit, valid while core_load=1
- core_step  out  1  advance core one keystream bit
- core_ks_bit  in  1  core keystream bit, registered in core; updated on the edge where core_step=1
- busy  out  1  high in every state except IDLE
- done  out  1  one-cycle pulse on normal session completion

## Operation
- States: IDLE, LOAD, WARM, GEN, WAIT_IN, OUT, DONE.
- IDLE: if start=1, latch key and byte_count, clear the index, and go to LOAD.
- LOAD: 64 cycles. core_load=1, core_key_bit=key_q[idx], idx 0..63 (LSB first). After idx=63, go to WARM, or to GEN/DONE if WARMUP=0.
- WARM: WARMUP cycles with core_step=1; keystream bits are discarded. Then go to GEN if remaining≠0, else DONE.
- GEN: 9 cycles, g=0..8.
  - core_step=1 for g=0..7.
  - At g=1..8, ks_byte[g-1]←core_ks_bit.
  - Then go to WAIT_IN.
- WAIT_IN: in_ready=1. On in_valid=1: out_byte←in_byte^ks_byte, out_valid←1, go to OUT.
- OUT: out_valid=1 and out_byte held stable. On out_ready=1: out_valid←0, remaining←remaining-1. Go to DONE if the new remaining is 0, else GEN.
- DONE: done=1 for exactly one cycle, then IDLE.
- core_step and core_load are never both 1. Both are 0 outside LOAD/WARM/GEN.
- remaining is 16 bits and never decrements below 0. byte_count=0 yields no output bytes.

## Timing
- Reset values: in_ready=0, out_valid=0, out_byte=0, core_load=0, core_key_bit=0, core_step=0, busy=0, done=0, state=IDLE, all counters 0.
- start accepted at edge T:
  - LOAD occupies cycles T+1..T+64.
  - WARM occupies T+65..T+64+WARMUP.
  - First GEN cycle is T+65+WARMUP.
- Per-byte minimum: 9 (GEN) + 1 (WAIT_IN) + 1 (OUT) = 11 cycles.
- Keystream is never advanced while waiting for in_valid or out_ready (no core_step in WAIT_IN/OUT).
- start while busy=1 is ignored, and key/byte_count are not re-latched.
- abort=1 (any non-IDLE state) has effect at the next edge:
  - state←IDLE; out_valid, in_ready, core_load, core_step ← 0.
  - done is not pulsed.
- abort has priority over start in the same cycle.
- rst has priority over abort and start. rst mid-session restores all reset values at the next edge.

## Test plan
- Reset: assert rst for 2 cycles mid-GEN, then release → all outputs 0 and busy=0. Next start proceeds normally.
- Key load: key=64'h0123456789ABCDEF, byte_count=1, WARMUP=100.
  - core_load=1 for exactly 64 cycles, and core_key_bit sequence equals key bits 0..63.
  - core_step=1 for exactly 100 following cycles.
  - First GEN step at T+165.
- Encrypt: bench core model returns ks bits 1,0,1,1,0,0,1,0 (ks_byte=0x4D), in_byte=0xFF with in_valid high → out_byte=0xB2 and out_valid=1; then done pulses one cycle after out_ready handshake.
- Backpressure: byte_count=2.
  - With in_valid low for 4 cycles, then out_ready low for 5 cycles: in_ready stays high while waiting, and out_byte/out_valid stay stable.
  - core_step=0 throughout the stalls.
  - Exactly 16 GEN steps in total.
- Zero length: byte_count=0 → done at T+65+WARMUP; out_valid and in_ready never assert.
- Abort/start collisions: abort during WAIT_IN → IDLE next cycle with no done. start pulsed during WARM → ignored, and the WARM step count is unchanged.
